alu_result_stage: RTL and testbench
===================================

# alu_result_stage

Execute-to-writeback stage directly downstream of the 16-bit ALU. Captures each ALU result (ALU_OUT, FLAG_OUT {S,Z,C,V}) with its opcode, destination and branch condition code. It maintains the architectural flag register and evaluates the branch condition. Results are buffered in a 2-entry FIFO behind a valid/ready handshake toward register-file writeback.

## Interface
- No parameters. Widths are fixed: data 16, flags 4, opcode 4, dest 3, cond 4, depth 2.
- CLK  in  1  sole clock, all state on rising edge.
- RST_N  in  1  reset; asynchronous, active-low.
- IN_VALID  in  1  upstream beat valid.
- IN_READY  out  1  stage can accept: high when fewer than 2 entries are held.
- ALU_OUT  in  16  ALU result.
- FLAG_OUT  in  4  ALU flags {S,Z,C,V}.
- S_ALU  in  4  opcode of this beat; 4'b1111 (INON) means no flag update.
- DEST  in  3  destination register index.
- WE  in  1  register writeback requested.
- COND  in  4  branch condition code (encoding below).
- CLR_V  in  1  clear sticky overflow. Ignored unless ALU_STICKY_V_EN is defined.
- OUT_VALID  out  1  head entry valid.
- OUT_READY  in  1  downstream accepts head.
- OUT_DATA  out  16  head result.
- OUT_DEST  out  3  head destination.
- OUT_WE  out  1  head writeback enable.
- OUT_COND_TRUE  out  1  head branch condition outcome.
- FLAGS  out  4  architectural flag register {S,Z,C,V}.

## Operation
- Push = IN_VALID & IN_READY. Pop = OUT_VALID & OUT_READY.
- IN_READY = (count != 2), driven combinationally from the registered count. A beat offered while full is not accepted, even if a pop happens in the same cycle.
- On push:
  - Next flags NF = FLAG_OUT if S_ALU != 4'b1111, else current FLAGS.
  - FLAGS <= NF.
  - The entry stores ALU_OUT, DEST, WE and cond_true = f(COND, NF).
- COND encoding, on NF {S,Z,C,V}:
  - 0 always; 1 Z; 2 !Z; 3 S; 4 !S; 5 C; 6 !C; 7 V; 8 !V.
  - 9 S^V (lt); 10 !(S^V) (ge); 11 (S^V)|Z (le); 12 !((S^V)|Z) (gt).
  - 13–15 never (0).
- FIFO is 2 entries, head/tail pointers 1 bit each, wrapping 1→0; count is 0..2. Outputs always show the head entry. OUT_* data are don't-care when OUT_VALID=0, but are driven to 0 after reset.
- Push and pop in the same cycle with count=1: head is replaced by the new entry; count stays 1.
- Push and pop in the same cycle with count=0: not possible, because OUT_VALID=0.
- Head entry is stable while OUT_VALID & !OUT_READY.
- INON beats still push an entry; only the flag update is suppressed.

## Timing
- Reset (RST_N low, asynchronous): count=0, pointers=0, FLAGS=4'b0000, OUT_VALID=0, OUT_DATA=0, OUT_DEST=0, OUT_WE=0, OUT_COND_TRUE=0. IN_READY=1.
- A push at edge N with the FIFO empty gives OUT_VALID=1 from cycle N+1: latency 1.
- FLAGS reflects a push from the cycle after the push edge.
- Back-to-back: sustains 1 beat/cycle while OUT_READY=1.
- With OUT_READY low: accepts 2 beats, then IN_READY=0 until the first pop edge.
- Reset asserted mid-operation: all entries and FLAGS are lost immediately, with no waiting for a clock edge.

## Configuration
- ALU_STICKY_V_EN defined: FLAGS[0] (V) is sticky.
  - On push, V <= FLAGS[0] | NF[0].
  - CLR_V high on a clock edge forces V to 0; CLR_V takes priority over a concurrent push setting V.
  - cond_true uses the sticky V, i.e. the value written to FLAGS.
- ALU_STICKY_V_EN undefined: V follows NF exactly. CLR_V is unused.

## Test plan
- Reset then single beat: push ALU_OUT=16'h1234, FLAG_OUT=4'b0000, S_ALU=0, DEST=3, WE=1, COND=2 → next cycle OUT_VALID=1, OUT_DATA=16'h1234, OUT_DEST=3, OUT_COND_TRUE=1, FLAGS=0.
- INON suppression: push FLAG_OUT=4'b0100 (Z) with S_ALU=0, then FLAG_OUT=4'b1000 with S_ALU=4'b1111, COND=1 → FLAGS stays 4'b0100; second entry OUT_COND_TRUE=1.
- Backpressure: OUT_READY=0, push A, B, C → IN_READY=0 after B; C is not accepted. Raising OUT_READY pops A, then B, in order, and IN_READY returns to 1.
- Simultaneous push/pop at count=1 → count stays 1, OUT_DATA advances to the new value the next cycle, no loss.
- Signed conditions: FLAG_OUT=4'b1000 (S=1, V=0), COND=9 → cond_true=1. Same flags with COND=12 → 0.
- ALU_STICKY_V_EN: push V=1, then push V=0 → FLAGS[0]=1. Pulse CLR_V with no push → FLAGS[0]=0. Async reset mid-burst → OUT_VALID=0 immediately.

Source files
------------

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - ALU execute-to-writeback result stage with flag register and 2-entry FIFO
// Optional feature macro: ALU_STICKY_V_EN (sticky overflow flag, cleared by CLR_V)
module alu_result_stage (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [15:0] ALU_OUT,
  input  logic [3:0]  FLAG_OUT,
  input  logic [3:0]  S_ALU,
  input  logic [2:0]  DEST,
  input  logic        WE,
  input  logic [3:0]  COND,
  input  logic        CLR_V,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [15:0] OUT_DATA,
  output logic [2:0]  OUT_DEST,
  output logic        OUT_WE,
  output logic        OUT_COND_TRUE,
  output logic [3:0]  FLAGS
);

  localparam logic [3:0] OP_INON = 4'b1111;

  // Flags are ordered {S,Z,C,V}; codes 13..15 never take the branch.
  function automatic logic cond_eval(input logic [3:0] code, input logic [3:0] f);
    logic s, z, c, v, lt;
    s  = f[3];
    z  = f[2];
    c  = f[1];
    v  = f[0];
    lt = s ^ v;
    case (code)
      4'd0:    cond_eval = 1'b1;
      4'd1:    cond_eval = z;
      4'd2:    cond_eval = ~z;
      4'd3:    cond_eval = s;
      4'd4:    cond_eval = ~s;
      4'd5:    cond_eval = c;
      4'd6:    cond_eval = ~c;
      4'd7:    cond_eval = v;
      4'd8:    cond_eval = ~v;
      4'd9:    cond_eval = lt;
      4'd10:   cond_eval = ~lt;
      4'd11:   cond_eval = lt | z;
      4'd12:   cond_eval = ~(lt | z);
      default: cond_eval = 1'b0;
    endcase
  endfunction

  logic [15:0] data_q [2];
  logic [15:0] data_d [2];
  logic [2:0]  dest_q [2];
  logic [2:0]  dest_d [2];
  logic        we_q   [2];
  logic        we_d   [2];
  logic        ct_q   [2];
  logic        ct_d   [2];
  logic        head_q, head_d;
  logic        tail_q, tail_d;
  logic [1:0]  count_q, count_d;
  logic [3:0]  flags_q, flags_d;

  logic        push, pop;
  logic [3:0]  nf;
  logic [3:0]  wr_flags;
  logic        new_ct;

  assign IN_READY      = (count_q != 2'd2);
  assign OUT_VALID     = (count_q != 2'd0);
  assign push          = IN_VALID & IN_READY;
  assign pop           = OUT_VALID & OUT_READY;
  assign OUT_DATA      = data_q[head_q];
  assign OUT_DEST      = dest_q[head_q];
  assign OUT_WE        = we_q[head_q];
  assign OUT_COND_TRUE = ct_q[head_q];
  assign FLAGS         = flags_q;

`ifndef ALU_STICKY_V_EN
  // Without sticky V there is nothing to clear.
  logic unused_clr_v;
  assign unused_clr_v = CLR_V;
`endif

  // Flag register update; the branch condition sees the value being written.
  always_comb begin
    nf       = (S_ALU != OP_INON) ? FLAG_OUT : flags_q;
    flags_d  = flags_q;
`ifdef ALU_STICKY_V_EN
    wr_flags = {nf[3:1], (flags_q[0] | nf[0]) & ~CLR_V};
    if (push) begin
      flags_d = wr_flags;
    end
    if (CLR_V) begin
      flags_d[0] = 1'b0;
    end
`else
    wr_flags = nf;
    if (push) begin
      flags_d = wr_flags;
    end
`endif
    new_ct = cond_eval(COND, wr_flags);
  end

  // FIFO storage, pointer and occupancy next-state.
  always_comb begin
    data_d  = data_q;
    dest_d  = dest_q;
    we_d    = we_q;
    ct_d    = ct_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) begin
      data_d[tail_q] = ALU_OUT;
      dest_d[tail_q] = DEST;
      we_d[tail_q]   = WE;
      ct_d[tail_q]   = new_ct;
      tail_d         = ~tail_q;
    end
    if (pop) begin
      head_d = ~head_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset clears all entries so outputs read zero.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        dest_q[i] <= '0;
        we_q[i]   <= 1'b0;
        ct_q[i]   <= 1'b0;
      end
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= 2'd0;
      flags_q <= 4'b0000;
    end else begin
      data_q  <= data_d;
      dest_q  <= dest_d;
      we_q    <= we_d;
      ct_q    <= ct_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      flags_q <= flags_d;
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - self-checking bench for alu_result_stage with queue reference model
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] alu_out;
  logic [3:0]  flag_out;
  logic [3:0]  s_alu;
  logic [2:0]  dest;
  logic        we;
  logic [3:0]  cond;
  logic        clr_v;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [2:0]  out_dest;
  logic        out_we;
  logic        out_cond_true;
  logic [3:0]  flags;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [15:0] d;
    logic [2:0]  dst;
    logic        w;
    logic        ct;
  } ent_t;

  ent_t       mq[$];
  logic [3:0] mflags;

  always #5 clk = ~clk;

  alu_result_stage dut (
    .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready),
    .ALU_OUT(alu_out), .FLAG_OUT(flag_out), .S_ALU(s_alu), .DEST(dest),
    .WE(we), .COND(cond), .CLR_V(clr_v), .OUT_VALID(out_valid),
    .OUT_READY(out_ready), .OUT_DATA(out_data), .OUT_DEST(out_dest),
    .OUT_WE(out_we), .OUT_COND_TRUE(out_cond_true), .FLAGS(flags)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Branch outcome straight from the condition table on flags {S,Z,C,V}.
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    bit s, z, cy, v, lt;
    s = f[3]; z = f[2]; cy = f[1]; v = f[0];
    lt = (s != v);
    case (c)
      0: return 1;  1: return z;   2: return !z;  3: return s;
      4: return !s; 5: return cy;  6: return !cy; 7: return v;
      8: return !v; 9: return lt; 10: return !lt; 11: return lt || z;
      12: return !(lt || z);
      default: return 0;
    endcase
  endfunction

  task automatic idle();
    in_valid = 0; alu_out = 0; flag_out = 0; s_alu = 0; dest = 0;
    we = 0; cond = 0; clr_v = 0;
  endtask

  task automatic beat(input logic [15:0] d, input logic [3:0] f, input logic [3:0] op,
                      input logic [2:0] ds, input logic w, input logic [3:0] c);
    in_valid = 1; alu_out = d; flag_out = f; s_alu = op; dest = ds; we = w; cond = c;
  endtask

  // Advance the model by the edge that is about to happen, then move to the next falling edge.
  task automatic step();
    bit         do_push, do_pop;
    logic [3:0] nf, wf;
    ent_t       e;
    do_push = in_valid && (mq.size() < 2);
    do_pop  = (mq.size() > 0) && out_ready;
    nf = (s_alu != 4'hF) ? flag_out : mflags;
`ifdef ALU_STICKY_V_EN
    wf = {nf[3:1], (mflags[0] | nf[0]) & !clr_v};
    if (do_push) mflags = wf;
    if (clr_v) mflags[0] = 1'b0;
`else
    wf = nf;
    if (do_push) mflags = wf;
`endif
    e.d = alu_out; e.dst = dest; e.w = we; e.ct = ref_cond(cond, wf);
    if (do_pop) void'(mq.pop_front());
    if (do_push) mq.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 0;
    mq.delete();
    mflags = 4'b0000;
    #12;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    idle(); out_ready = 0;
    do_reset();
    total++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", in_ready); else passed++;
    total++; if (flags !== 4'b0000) $display("FAIL reset_flags: got %b want 0000", flags); else passed++;
    total++; if ({out_data, out_dest, out_we, out_cond_true} !== 21'd0)
      $display("FAIL reset_outs: got %h/%h/%b/%b want 0", out_data, out_dest, out_we, out_cond_true); else passed++;
  endtask

  task automatic test_single_beat();
    out_ready = 0;
    beat(16'h1234, 4'b0000, 4'd0, 3'd3, 1'b1, 4'd2);
    step(); idle();
    total++; if (out_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", out_valid); else passed++;
    total++; if (out_data !== 16'h1234) $display("FAIL single_data: got %h want 1234", out_data); else passed++;
    total++; if (out_dest !== 3'd3) $display("FAIL single_dest: got %0d want 3", out_dest); else passed++;
    total++; if (out_we !== 1'b1) $display("FAIL single_we: got %b want 1", out_we); else passed++;
    total++; if (out_cond_true !== 1'b1) $display("FAIL single_cond: got %b want 1", out_cond_true); else passed++;
    total++; if (flags !== 4'b0000) $display("FAIL single_flags: got %b want 0000", flags); else passed++;
    out_ready = 1; step();
    total++; if (out_valid !== 1'b0) $display("FAIL single_drain: got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_inon();
    out_ready = 0;
    beat(16'h0011, 4'b0100, 4'd0, 3'd1, 1'b1, 4'd0); step();
    beat(16'h0022, 4'b1000, 4'hF, 3'd2, 1'b1, 4'd1); step(); idle();
    total++; if (flags !== 4'b0100) $display("FAIL inon_flags: got %b want 0100", flags); else passed++;
    total++; if (out_data !== 16'h0011) $display("FAIL inon_head: got %h want 0011", out_data); else passed++;
    out_ready = 1; step();
    total++; if (out_data !== 16'h0022) $display("FAIL inon_second: got %h want 0022", out_data); else passed++;
    total++; if (out_cond_true !== 1'b1) $display("FAIL inon_cond: got %b want 1", out_cond_true); else passed++;
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 0;
    beat(16'hAAAA, 4'b0000, 4'd0, 3'd0, 1'b1, 4'd0); step();
    total++; if (in_ready !== 1'b1) $display("FAIL bp_ready_after_a: got %b want 1", in_ready); else passed++;
    beat(16'hBBBB, 4'b0000, 4'd0, 3'd1, 1'b1, 4'd0); step();
    total++; if (in_ready !== 1'b0) $display("FAIL bp_ready_after_b: got %b want 0", in_ready); else passed++;
    beat(16'hCCCC, 4'b0000, 4'd0, 3'd2, 1'b1, 4'd0); step();
    total++; if (out_data !== 16'hAAAA) $display("FAIL bp_hold_a: got %h want aaaa", out_data); else passed++;
    // Full with a pop in the same cycle: C still must not enter.
    out_ready = 1; step(); idle();
    total++; if (out_data !== 16'hBBBB) $display("FAIL bp_pop_b: got %h want bbbb", out_data); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL bp_ready_back: got %b want 1", in_ready); else passed++;
    step();
    total++; if (out_valid !== 1'b0) $display("FAIL bp_c_dropped: got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_push_pop();
    out_ready = 0;
    beat(16'h5555, 4'b0000, 4'd0, 3'd4, 1'b0, 4'd0); step();
    out_ready = 1;
    beat(16'h6666, 4'b0010, 4'd3, 3'd5, 1'b1, 4'd5); step(); idle();
    total++; if (out_data !== 16'h6666) $display("FAIL pp_data: got %h want 6666", out_data); else passed++;
    total++; if (out_valid !== 1'b1 || in_ready !== 1'b1)
      $display("FAIL pp_count: got valid %b ready %b want 1 1", out_valid, in_ready); else passed++;
    total++; if (out_cond_true !== 1'b1) $display("FAIL pp_cond: got %b want 1", out_cond_true); else passed++;
    step();
    total++; if (out_valid !== 1'b0) $display("FAIL pp_drain: got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_signed();
    out_ready = 1;
    beat(16'h0100, 4'b1000, 4'd0, 3'd0, 1'b0, 4'd9); step();
    total++; if (out_cond_true !== 1'b1) $display("FAIL signed_lt: got %b want 1", out_cond_true); else passed++;
    beat(16'h0200, 4'b1000, 4'd0, 3'd0, 1'b0, 4'd12); step(); idle();
    total++; if (out_cond_true !== 1'b0) $display("FAIL signed_gt: got %b want 0", out_cond_true); else passed++;
    step();
  endtask

`ifdef ALU_STICKY_V_EN
  task automatic test_v_flag();
    out_ready = 1;
    beat(16'h0001, 4'b0001, 4'd0, 3'd0, 1'b0, 4'd0); step();
    beat(16'h0002, 4'b0000, 4'd0, 3'd0, 1'b0, 4'd7); step(); idle();
    total++; if (flags[0] !== 1'b1) $display("FAIL sticky_hold: got %b want 1", flags[0]); else passed++;
    total++; if (out_cond_true !== 1'b1) $display("FAIL sticky_cond: got %b want 1", out_cond_true); else passed++;
    clr_v = 1; step(); clr_v = 0;
    total++; if (flags[0] !== 1'b0) $display("FAIL sticky_clear: got %b want 0", flags[0]); else passed++;
    beat(16'h0003, 4'b0001, 4'd0, 3'd0, 1'b0, 4'd7); clr_v = 1; step(); idle();
    total++; if (flags[0] !== 1'b0) $display("FAIL sticky_clr_prio: got %b want 0", flags[0]); else passed++;
    total++; if (out_cond_true !== 1'b0) $display("FAIL sticky_clr_cond: got %b want 0", out_cond_true); else passed++;
    step();
  endtask
`else
  task automatic test_v_flag();
    out_ready = 1;
    beat(16'h0001, 4'b0001, 4'd0, 3'd0, 1'b0, 4'd0); step();
    beat(16'h0002, 4'b0000, 4'd0, 3'd0, 1'b0, 4'd7); step(); idle();
    total++; if (flags[0] !== 1'b0) $display("FAIL v_follow: got %b want 0", flags[0]); else passed++;
    total++; if (out_cond_true !== 1'b0) $display("FAIL v_follow_cond: got %b want 0", out_cond_true); else passed++;
    beat(16'h0003, 4'b0001, 4'd0, 3'd0, 1'b0, 4'd0); step(); idle();
    clr_v = 1; step(); clr_v = 0;
    total++; if (flags[0] !== 1'b1) $display("FAIL v_clr_ignored: got %b want 1", flags[0]); else passed++;
  endtask
`endif

  task automatic test_async_reset();
    out_ready = 0;
    beat(16'h7777, 4'b1111, 4'd0, 3'd7, 1'b1, 4'd0); step();
    beat(16'h8888, 4'b0110, 4'd0, 3'd6, 1'b1, 4'd0); step(); idle();
    #2;
    rst_n = 0;
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL areset_valid: got %b want 0", out_valid); else passed++;
    total++; if (flags !== 4'b0000) $display("FAIL areset_flags: got %b want 0000", flags); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL areset_ready: got %b want 1", in_ready); else passed++;
    mq.delete();
    mflags = 4'b0000;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_random();
    ent_t h;
    for (int i = 0; i < 600; i++) begin
      total++; if (in_ready !== (mq.size() != 2))
        $display("FAIL rnd_ready[%0d]: got %b want %b", i, in_ready, mq.size() != 2); else passed++;
      total++; if (out_valid !== (mq.size() != 0))
        $display("FAIL rnd_valid[%0d]: got %b want %b", i, out_valid, mq.size() != 0); else passed++;
      total++; if (flags !== mflags)
        $display("FAIL rnd_flags[%0d]: got %b want %b", i, flags, mflags); else passed++;
      if (mq.size() != 0) begin
        h = mq[0];
        total++; if ({out_data, out_dest, out_we, out_cond_true} !== {h.d, h.dst, h.w, h.ct})
          $display("FAIL rnd_head[%0d]: got %h/%0d/%b/%b want %h/%0d/%b/%b", i, out_data, out_dest,
                   out_we, out_cond_true, h.d, h.dst, h.w, h.ct); else passed++;
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      alu_out   = 16'($urandom);
      flag_out  = 4'($urandom);
      s_alu     = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      dest      = 3'($urandom);
      we        = 1'($urandom);
      cond      = 4'($urandom);
      clr_v     = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    idle();
  endtask

  initial begin
    rst_n = 0;
    idle();
    out_ready = 0;
    test_reset();
    test_single_beat();
    test_inon();
    test_backpressure();
    test_push_pop();
    test_signed();
    test_v_flag();
    test_async_reset();
    do_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
